// File: rtl/mem_sync_be_clr_if.sv
//==============================================================================
// mem_sync_be_clr_if : request/response bus of the synchronous byte-enable memory
// Rev 1.0
//==============================================================================
`default_nettype none

interface mem_sync_be_clr_if #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 16
);
   logic                   req;
   logic                   we;
   logic [BITS_DATA/8-1:0] be;
   logic [BITS_ADDR-1:0]   address;
   logic [BITS_DATA-1:0]   data_in;
   logic                   ready;
   logic                   rvalid;
   logic [BITS_DATA-1:0]   data_out;

   modport master (
      output req, we, be, address, data_in,
      input  ready, rvalid, data_out
   );

   modport slave (
      input  req, we, be, address, data_in,
      output ready, rvalid, data_out
   );
endinterface

`default_nettype wire

// File: rtl/mem_sync_be_clr.sv
//==============================================================================
// mem_sync_be_clr : single-port memory, registered reads, byte writes, HW clear
// Rev 1.0
//==============================================================================
`default_nettype none

module mem_sync_be_clr #(
   parameter int BITS_DATA      = 32,
   parameter int BITS_ADDR      = 16,
   parameter int CLEAR_ON_RESET = 1
) (
   input  wire logic       clk,
   input  wire logic       reset,
   mem_sync_be_clr_if.slave bus
);
   localparam int NUM_BYTES = BITS_DATA / 8;
   localparam int DEPTH     = 2 ** BITS_ADDR;
   localparam logic [BITS_ADDR:0] LAST_WORD = (BITS_ADDR + 1)'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   state_t                 state_q, state_d;
   logic [BITS_ADDR:0]     cnt_q, cnt_d;
   logic                   rvalid_q, rvalid_d;
   logic [BITS_DATA-1:0]   data_out_q, data_out_d;
   logic [BITS_DATA-1:0]   mem_q [DEPTH];

   logic                   ready;
   logic                   accept;
   logic                   wr_en;
   logic [BITS_ADDR-1:0]   wr_addr;
   logic [BITS_DATA-1:0]   wr_data;
   logic [NUM_BYTES-1:0]   wr_be;

   always_comb begin
      ready      = (state_q == ST_IDLE) && !reset;
      accept     = bus.req && ready;
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_en      = 1'b0;
      wr_addr    = bus.address;
      wr_data    = bus.data_in;
      wr_be      = bus.be;
      rvalid_d   = accept && !bus.we;
      data_out_d = data_out_q;

      case (state_q)
         ST_CLEAR: begin
            // The clear port reuses the normal write path; requests are ignored here.
            wr_en   = !reset;
            wr_addr = cnt_q[BITS_ADDR-1:0];
            wr_data = '0;
            wr_be   = '1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            wr_en = accept && bus.we;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase

      if (accept && !bus.we) begin
         data_out_d = mem_q[bus.address];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RESET_STATE;
         cnt_q      <= '0;
         rvalid_q   <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rvalid_q   <= rvalid_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is deliberately outside the reset domain; only CLEAR zeroes it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_be[b]) begin
               mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Outputs are masked while reset is held so an in-flight read is dropped.
   assign bus.ready    = ready;
   assign bus.rvalid   = rvalid_q && !reset;
   assign bus.data_out = reset ? '0 : data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_sync_be_clr.sv
//==============================================================================
// tb_mem_sync_be_clr : scoreboard bench, one clearing and one non-clearing memory
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_mem_sync_be_clr;
   logic clk = 1'b0;
   logic rst_c;
   logic rst_n;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t q_c[$];
   exp_t q_n[$];

   mem_sync_be_clr_if #(.BITS_DATA(32), .BITS_ADDR(4)) if_c ();
   mem_sync_be_clr_if #(.BITS_DATA(32), .BITS_ADDR(4)) if_n ();

   mem_sync_be_clr #(.BITS_DATA(32), .BITS_ADDR(4), .CLEAR_ON_RESET(1)) u_dut_c (
      .clk   (clk),
      .reset (rst_c),
      .bus   (if_c.slave)
   );

   mem_sync_be_clr #(.BITS_DATA(32), .BITS_ADDR(4), .CLEAR_ON_RESET(0)) u_dut_n (
      .clk   (clk),
      .reset (rst_n),
      .bus   (if_n.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic drive(input bit sel, input logic r, input logic w, input logic [3:0] be,
                        input logic [3:0] a, input logic [31:0] d);
      if (sel == 1'b0) begin
         if_c.req = r; if_c.we = w; if_c.be = be; if_c.address = a; if_c.data_in = d;
      end else begin
         if_n.req = r; if_n.we = w; if_n.be = be; if_n.address = a; if_n.data_in = d;
      end
   endtask

   task automatic wr(input bit sel, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      drive(sel, 1'b1, 1'b1, be, a, d);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
   endtask

   task automatic rd(input bit sel, input logic [3:0] a, input logic [31:0] exp);
      exp_t e;
      e.cyc  = cyc + 1;
      e.data = exp;
      if (sel == 1'b0) q_c.push_back(e);
      else             q_n.push_back(e);
      drive(sel, 1'b1, 1'b0, 4'h0, a, 32'h0);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
   endtask

   // Monitor: every cycle rvalid must match the scoreboard, and data must match on a hit.
   always @(negedge clk) begin
      if (q_c.size() > 0 && q_c[0].cyc == cyc) begin
         check("rvalid_c", 32'(if_c.rvalid), 32'd1);
         check("rdata_c", if_c.data_out, q_c[0].data);
         void'(q_c.pop_front());
      end else begin
         check("idle_rvalid_c", 32'(if_c.rvalid), 32'd0);
      end
      if (q_n.size() > 0 && q_n[0].cyc == cyc) begin
         check("rvalid_n", 32'(if_n.rvalid), 32'd1);
         check("rdata_n", if_n.data_out, q_n[0].data);
         void'(q_n.pop_front());
      end else begin
         check("idle_rvalid_n", 32'(if_n.rvalid), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n_low;
      rst_c = 1'b1;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

      @(negedge clk);
      check("reset_ready_c", 32'(if_c.ready), 32'd0);
      check("reset_dout_c", if_c.data_out, 32'h0);
      check("reset_ready_n", 32'(if_n.ready), 32'd0);
      @(posedge clk); #1;
      rst_c = 1'b0;
      rst_n = 1'b0;

      // Clear phase: count ready-low cycles while a write to addr 2 is held on the bus.
      n_low = 0;
      drive(1'b0, 1'b1, 1'b1, 4'hF, 4'd2, 32'd7);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (if_c.ready) break;
         n_low++;
         if (n_low >= 10) drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      check("clear_cycles", 32'(n_low), 32'd16);
      @(posedge clk); #1;

      for (int a = 0; a < 16; a++) rd(1'b0, 4'(a), 32'h0);

      wr(1'b0, 4'd3, 32'hDEADBEEF, 4'hF);
      wr(1'b0, 4'd3, 32'h11223344, 4'b0101);
      rd(1'b0, 4'd3, 32'hDE22BE44);

      wr(1'b0, 4'd1, 32'd1, 4'hF);
      wr(1'b0, 4'd2, 32'd2, 4'hF);
      wr(1'b0, 4'd3, 32'd3, 4'hF);
      rd(1'b0, 4'd1, 32'd1);
      rd(1'b0, 4'd2, 32'd2);
      rd(1'b0, 4'd3, 32'd3);
      @(negedge clk);
      @(negedge clk);
      check("post_burst_rvalid", 32'(if_c.rvalid), 32'd0);
      check("post_burst_hold", if_c.data_out, 32'd3);
      @(posedge clk); #1;

      wr(1'b0, 4'd5, 32'hA5A5A5A5, 4'hF);
      rd(1'b0, 4'd5, 32'hA5A5A5A5);
      wr(1'b0, 4'd5, 32'hFFFFFFFF, 4'h0);
      rd(1'b0, 4'd5, 32'hA5A5A5A5);

      // Non-clearing instance: reset right after a read accept drops the result.
      wr(1'b1, 4'd9, 32'h12345678, 4'hF);
      wr(1'b1, 4'd10, 32'hCAFEF00D, 4'hF);
      drive(1'b1, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_drop_rvalid_n", 32'(if_n.rvalid), 32'd0);
      check("rst_ready_n", 32'(if_n.ready), 32'd0);
      check("rst_dout_n", if_n.data_out, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("noclear_ready_n", 32'(if_n.ready), 32'd1);
      @(posedge clk); #1;
      rd(1'b1, 4'd9, 32'h12345678);
      rd(1'b1, 4'd10, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(q_c.size() + q_n.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
